// File: rtl/fft_8p_unload_if.sv
// rtl/fft_8p_unload_if.sv - handshake/data bundle for the 8-point FFT unload buffer
// Purpose: groups the input-sample side, the output-bin side and the overflow flag.
// Signals:
//   in_en, in_r, in_i   : sample strobe and signed real/imag parts from the FFT
//   in_ready            : write bank can take a sample
//   out_valid/out_ready : output handshake
//   out_r, out_i        : signed real/imag parts of the outgoing bin
//   out_idx, out_last   : natural-order bin index, high with index 7
//   overflow            : sticky, set on any dropped input sample
// Modports: slave = unload buffer, master = FFT source / downstream sink.
interface fft_8p_unload_if;
  logic               in_en;
  logic signed [15:0] in_r;
  logic signed [15:0] in_i;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_r;
  logic signed [15:0] out_i;
  logic [2:0]         out_idx;
  logic               out_last;
  logic               overflow;

  modport slave (
    input  in_en, in_r, in_i, out_ready,
    output in_ready, out_valid, out_r, out_i, out_idx, out_last, overflow
  );

  modport master (
    output in_en, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_idx, out_last, overflow
  );
endinterface

// File: rtl/fft_8p_unload.sv
// rtl/fft_8p_unload.sv - ping-pong buffer reordering bit-reversed FFT bins to natural order
// Purpose: frames of 8 bins arrive in bit-reversed order and leave in natural order.
//   Each arrival k is written to address bitrev3(k) of the write bank; the read side
//   walks its bank linearly. Two banks let one frame drain while the next fills.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fft_8p_unload_if.slave (sample input, bin output, overflow flag)
module fft_8p_unload (
  input  logic            clk,
  input  logic            rst_n,
  fft_8p_unload_if.slave  bus
);

  // Bank storage: {real, imag} per entry, intentionally not reset.
  logic [31:0] r_mem [2][8];

  logic       r_wbank;
  logic       r_rbank;
  logic [2:0] r_wcnt;
  logic [2:0] r_rcnt;
  logic [1:0] r_full;
  logic       r_overflow;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_drop;
  logic        w_out_valid;
  logic        w_rd_hs;
  logic [2:0]  w_waddr;
  logic [31:0] w_rdata;

  assign w_in_ready  = !r_full[r_wbank];
  assign w_accept    = bus.in_en && w_in_ready;
  assign w_drop      = bus.in_en && !w_in_ready;
  assign w_out_valid = r_full[r_rbank];
  assign w_rd_hs     = w_out_valid && bus.out_ready;

  // Arrival k holds bin bitrev3(k); storing it there makes the read side linear.
  assign w_waddr = {r_wcnt[0], r_wcnt[1], r_wcnt[2]};
  assign w_rdata = r_mem[r_rbank][r_rcnt];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wbank][w_waddr] <= {bus.in_r, bus.in_i};
    end
  end

  // A write can only target a non-full bank and a release only a full one,
  // so a frame completion and a release on the same edge never hit the same flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbank    <= 1'b0;
      r_rbank    <= 1'b0;
      r_wcnt     <= 3'd0;
      r_rcnt     <= 3'd0;
      r_full     <= 2'b00;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wcnt <= r_wcnt + 3'd1;
        if (r_wcnt == 3'd7) begin
          r_full[r_wbank] <= 1'b1;
          r_wbank         <= ~r_wbank;
        end
      end
      if (w_rd_hs) begin
        r_rcnt <= r_rcnt + 3'd1;
        if (r_rcnt == 3'd7) begin
          r_full[r_rbank] <= 1'b0;
          r_rbank         <= ~r_rbank;
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Outputs are forced to zero whenever nothing valid is presented.
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_r     = w_out_valid ? w_rdata[31:16] : 16'sd0;
  assign bus.out_i     = w_out_valid ? w_rdata[15:0]  : 16'sd0;
  assign bus.out_idx   = w_out_valid ? r_rcnt : 3'd0;
  assign bus.out_last  = w_out_valid && (r_rcnt == 3'd7);
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_fft_8p_unload.sv
// tb/tb_fft_8p_unload.sv - self-checking bench for fft_8p_unload
// Purpose: table-driven frames plus hand sequences (backpressure, stall, reset, streaming);
//   expected bins are queued when a frame's 8th sample is accepted and compared on handshake.
// Ports: none (top-level bench).
module tb_fft_8p_unload;

  logic clk;
  logic rst_n;

  fft_8p_unload_if bus ();

  fft_8p_unload dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    shortint in_r  [8];
    shortint in_i  [8];
    shortint exp_r [8];
    shortint exp_i [8];
  } vec_t;

  typedef struct {
    logic signed [15:0] r;
    logic signed [15:0] i;
    logic [2:0]         idx;
    logic               last;
  } exp_t;

  vec_t    tbl [2];
  exp_t    q [$];
  shortint cur_r  [8];
  shortint cur_i  [8];
  shortint cur_er [8];
  shortint cur_ei [8];

  int checks;
  int failures;
  int stall_cnt;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int bitrev3(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  // Output monitor: scoreboard compare on handshake, hold check after stalls,
  // zero check while idle.
  logic               prev_stall;
  logic signed [15:0] prev_r;
  logic signed [15:0] prev_i;
  logic [2:0]         prev_idx;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_idx", 32'(bus.out_idx), 32'(prev_idx));
        chk("stall_r", bus.out_r, prev_r);
        chk("stall_i", bus.out_i, prev_i);
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = q.pop_front();
            chk("out_r", bus.out_r, e.r);
            chk("out_i", bus.out_i, e.i);
            chk("out_idx", 32'(bus.out_idx), 32'(e.idx));
            chk("out_last", 32'(bus.out_last), 32'(e.last));
          end
        end
      end else begin
        chk("idle_r", bus.out_r, 0);
        chk("idle_idx", 32'(bus.out_idx), 0);
        chk("idle_last", 32'(bus.out_last), 0);
      end
      prev_stall <= bus.out_valid && !bus.out_ready;
      prev_r     <= bus.out_r;
      prev_i     <= bus.out_i;
      prev_idx   <= bus.out_idx;
    end
  end

  task automatic check_reset_state();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_out_r", bus.out_r, 0);
    chk("rst_out_i", bus.out_i, 0);
    chk("rst_out_idx", 32'(bus.out_idx), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
  endtask

  // Waits (with in_en low) for in_ready, then presents one sample for one edge.
  task automatic push_sample(input shortint r, input shortint i);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      stall_cnt++;
      w++;
      @(negedge clk);
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    bus.in_en = 1'b1;
    bus.in_r  = r;
    bus.in_i  = i;
    @(posedge clk);
    #1;
    bus.in_en = 1'b0;
  endtask

  task automatic send_frame(input bit chk_timing);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      if (chk_timing && k == 7) chk("valid_before_8th", 32'(bus.out_valid), 0);
      push_sample(cur_r[k], cur_i[k]);
    end
    for (int n = 0; n < 8; n++) begin
      e.r    = cur_er[n];
      e.i    = cur_ei[n];
      e.idx  = 3'(n);
      e.last = (n == 7);
      q.push_back(e);
    end
    if (chk_timing) chk("valid_after_8th", 32'(bus.out_valid), 1);
  endtask

  task automatic random_frame();
    for (int k = 0; k < 8; k++) begin
      cur_r[k] = shortint'($urandom);
      cur_i[k] = shortint'($urandom);
    end
    for (int n = 0; n < 8; n++) begin
      cur_er[n] = cur_r[bitrev3(n)];
      cur_ei[n] = cur_i[bitrev3(n)];
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 400 && q.size() != 0; c++) @(posedge clk);
    chk("drain_left", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("drained_valid", 32'(bus.out_valid), 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    stall_cnt = 0;

    tbl[0].in_r  = '{10, 11, 12, 13, 14, 15, 16, 17};
    tbl[0].in_i  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[0].exp_r = '{10, 14, 12, 16, 11, 15, 13, 17};
    tbl[0].exp_i = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].in_r  = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};
    tbl[1].in_i  = '{1, 2, 3, 4, 5, 6, 7, 8};
    tbl[1].exp_r = '{0, 0, 32767, -32767, 23170, -23170, 23170, -23170};
    tbl[1].exp_i = '{1, 5, 3, 7, 2, 6, 4, 8};

    rst_n         = 1'b0;
    bus.in_en     = 1'b0;
    bus.in_r      = '0;
    bus.in_i      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Table frames: ramp (with output timing) and sinusoid.
    bus.out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      cur_r  = tbl[t].in_r;
      cur_i  = tbl[t].in_i;
      cur_er = tbl[t].exp_r;
      cur_ei = tbl[t].exp_i;
      send_frame(t == 0);
      wait_drain();
    end

    // Backpressure: 16 samples fill both banks, 17th is dropped.
    bus.out_ready = 1'b0;
    random_frame();
    send_frame(1'b0);
    random_frame();
    send_frame(1'b0);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_overflow_pre", 32'(bus.overflow), 0);
    @(negedge clk);
    bus.in_en = 1'b1;
    bus.in_r  = 16'sh7abc;
    @(posedge clk);
    #1;
    bus.in_en = 1'b0;
    chk("bp_overflow", 32'(bus.overflow), 1);
    chk("bp_in_ready_hold", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    wait_drain();

    // Stall stability: out_ready pattern 1,0,0,1 while draining two frames.
    bus.out_ready = 1'b0;
    random_frame();
    send_frame(1'b0);
    random_frame();
    send_frame(1'b0);
    for (int c = 0; c < 400 && q.size() != 0; c++) begin
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_drain();

    // Reset after 5 samples of a frame; only the next frame may come out.
    for (int k = 0; k < 5; k++) push_sample(shortint'(100 + k), shortint'(-k));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    random_frame();
    send_frame(1'b0);
    wait_drain();
    chk("rst_frame_overflow", 32'(bus.overflow), 0);

    // Streaming: 4 frames back to back, in_ready must never drop.
    stall_cnt = 0;
    for (int f = 0; f < 4; f++) begin
      random_frame();
      send_frame(1'b0);
    end
    chk("stream_in_ready_stalls", stall_cnt, 0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
